// File: rtl/minmax_tracker_pkg.sv
// minmax_tracker_pkg: shared default widths and FSM state encoding for the extremum tracker
package minmax_tracker_pkg;
  localparam int DEF_WIDTH = 20;
  localparam int DEF_CNT_W = 16;
  typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;
endpackage

// File: rtl/minmax_tracker_if.sv
// minmax_tracker_if: sample stream and statistics bundle for minmax_tracker
//   master (source): drives clear, in_valid, in_data; observes in_ready and all statistics
//   slave (tracker): the mirror image
interface minmax_tracker_if
  import minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic clear;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] max_out;
  logic [WIDTH-1:0] min_out;
  logic [CNT_W-1:0] sample_cnt;
  logic cnt_sat;
  logic stats_valid;
  logic new_max;
  logic new_min;
  modport master (
    output clear, in_valid, in_data,
    input in_ready, max_out, min_out, sample_cnt, cnt_sat, stats_valid, new_max, new_min
  );
  modport slave (
    input clear, in_valid, in_data,
    output in_ready, max_out, min_out, sample_cnt, cnt_sat, stats_valid, new_max, new_min
  );
endinterface

// File: rtl/minmax_tracker_compare_chain.sv
// compare_chain: unsigned WIDTH-bit magnitude compare built as a cascade of 4-bit slices
//   a, b : operands
//   lt/gt/eq : a < b, a > b, a == b
// The first slice (from the MSB) that differs decides; later slices only matter while eq holds.
module compare_chain #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);
  localparam int N = WIDTH / 4;
  logic [N:0] l, g, e;
  assign l[0] = 1'b0;
  assign g[0] = 1'b0;
  assign e[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_slice
    localparam int H = WIDTH - 1 - 4 * i;
    assign l[i+1] = l[i] | (e[i] & (a[H -: 4] < b[H -: 4]));
    assign g[i+1] = g[i] | (e[i] & (a[H -: 4] > b[H -: 4]));
    assign e[i+1] = e[i] & (a[H -: 4] == b[H -: 4]);
  end
  assign lt = l[N];
  assign gt = g[N];
  assign eq = e[N];
endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: two-stage streaming running max/min tracker with saturating sample count
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of minmax_tracker_if (clear, sample handshake, statistics)
// Stage 1 captures an accepted sample; stage 2 compares it against the registered
// extremes and updates them, so back-to-back samples always see up-to-date extremes.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  minmax_tracker_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] smp_q, max_q, min_q, max_d, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic smp_v, sv_q, sv_d, nmax_q, nmax_d, nmin_q, nmin_d;
  logic acc, sat, first, upd_max, upd_min, gt_max, lt_min;
  logic unused_max_lt, unused_max_eq, unused_min_gt, unused_min_eq;
  compare_chain #(.WIDTH(WIDTH)) u_cmp_max (
    .a(smp_q), .b(max_q), .lt(unused_max_lt), .gt(gt_max), .eq(unused_max_eq)
  );
  compare_chain #(.WIDTH(WIDTH)) u_cmp_min (
    .a(smp_q), .b(min_q), .lt(lt_min), .gt(unused_min_gt), .eq(unused_min_eq)
  );
  assign bus.in_ready    = !bus.clear;
  assign acc             = bus.in_valid && bus.in_ready;
  assign sat             = &cnt_q;
  assign bus.max_out     = max_q;
  assign bus.min_out     = min_q;
  assign bus.sample_cnt  = cnt_q;
  assign bus.cnt_sat     = sat;
  assign bus.stats_valid = sv_q;
  assign bus.new_max     = nmax_q;
  assign bus.new_min     = nmin_q;
  // The first sample after EMPTY seeds both extremes regardless of the compare results.
  always_comb begin
    first   = smp_v && state_q == EMPTY;
    upd_max = smp_v && (first || gt_max);
    upd_min = smp_v && (first || lt_min);
    state_d = bus.clear ? EMPTY : smp_v ? TRACK : state_q;
    max_d   = bus.clear ? '0 : upd_max ? smp_q : max_q;
    min_d   = bus.clear ? '0 : upd_min ? smp_q : min_q;
    nmax_d  = !bus.clear && upd_max;
    nmin_d  = !bus.clear && upd_min;
    cnt_d   = bus.clear ? '0 : (smp_v && !sat) ? cnt_q + 1'b1 : cnt_q;
    sv_d    = !bus.clear && (sv_q || smp_v);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      smp_q   <= '0;
      smp_v   <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      nmax_q  <= 1'b0;
      nmin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= acc ? bus.in_data : smp_q;
      smp_v   <= acc;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      nmax_q  <= nmax_d;
      nmin_q  <= nmin_d;
    end
  end
endmodule
